// File: rtl/fib_seq_engine_pkg.sv
// Shared types and default sizes for the Fibonacci recurrence engine.
// Optional modulus feature is controlled by FIB_SEQ_ENGINE_MOD_EN.
package fib_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam int FIB_W_DEF   = 32;
    localparam int FIB_N_W_DEF = 6;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Host load/strobe bundle for fib_seq_engine. The host drives the job
// (master); the engine answers with busy/done/result (slave).
// FIB_SEQ_ENGINE_MOD_EN adds the modulus field.
interface fib_seq_engine_if
    import fib_seq_pkg::*;
#(
    parameter int W   = FIB_W_DEF,
    parameter int N_W = FIB_N_W_DEF
);
    logic           r_enable;
    logic [N_W-1:0] init_n;
    logic [W-1:0]   init_a;
    logic [W-1:0]   init_b;
    logic           sat_mode;
`ifdef FIB_SEQ_ENGINE_MOD_EN
    logic [W-1:0]   modulus;
`endif
    logic           busy;
    logic           w_enable;
    logic [W-1:0]   result;
    logic           overflow;

    modport master (
`ifdef FIB_SEQ_ENGINE_MOD_EN
        output modulus,
`endif
        output r_enable, init_n, init_a, init_b, sat_mode,
        input  busy, w_enable, result, overflow
    );

    modport slave (
`ifdef FIB_SEQ_ENGINE_MOD_EN
        input  modulus,
`endif
        input  r_enable, init_n, init_a, init_b, sat_mode,
        output busy, w_enable, result, overflow
    );
endinterface

// File: rtl/fib_seq_engine_alu.sv
// One recurrence step: next b from (a, b). Wrap or saturate on carry-out;
// with FIB_SEQ_ENGINE_MOD_EN and a non-zero modulus, reduce mod m instead.
module fib_step_alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sat,
`ifdef FIB_SEQ_ENGINE_MOD_EN
    input  logic [W-1:0] m,
`endif
    output logic [W-1:0] next_b,
    output logic         carry
);
    logic [W:0] s;

    assign s = {1'b0, a} + {1'b0, b};

    // Select the reduced/wrapped/saturated sum and report carry-out.
    always_comb begin
        next_b = s[W-1:0];
        carry  = s[W];
        if (s[W] && sat)
            next_b = '1;
`ifdef FIB_SEQ_ENGINE_MOD_EN
        // Seeds are below m, so s < 2m and one conditional subtract suffices.
        if (m != '0) begin
            carry  = 1'b0;
            next_b = (s >= {1'b0, m}) ? (s - {1'b0, m}) : s;
        end
`endif
    end
endmodule

// File: rtl/fib_seq_engine.sv
// Iterative Fibonacci recurrence engine: (a,b) <- (b,a+b) n times, returns a.
// One iteration per cycle, busy/done handshake, sticky overflow.
// FIB_SEQ_ENGINE_MOD_EN enables the optional modulus reduction.
module fib_seq_engine
    import fib_seq_pkg::*;
#(
    parameter int W   = FIB_W_DEF,
    parameter int N_W = FIB_N_W_DEF
) (
    input logic          clk,
    input logic          rst,
    fib_seq_engine_if.slave bus
);
    fib_state_t     state;
    logic [W-1:0]   a, b;
    logic [N_W-1:0] cnt;
    logic           sat_q;
    logic           busy_q, done_q, ovf_q;
    logic [W-1:0]   result_q;
    logic [W-1:0]   next_b;
    logic           carry;
`ifdef FIB_SEQ_ENGINE_MOD_EN
    logic [W-1:0]   m_q;
`endif

    fib_step_alu #(.W(W)) u_alu (
        .a      (a),
        .b      (b),
        .sat    (sat_q),
`ifdef FIB_SEQ_ENGINE_MOD_EN
        .m      (m_q),
`endif
        .next_b (next_b),
        .carry  (carry)
    );

    assign bus.busy     = busy_q;
    assign bus.w_enable = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

    // FSM, iteration counter and data registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
`ifdef FIB_SEQ_ENGINE_MOD_EN
            m_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.r_enable) begin
                        a      <= bus.init_a;
                        b      <= bus.init_b;
                        cnt    <= bus.init_n;
                        sat_q  <= bus.sat_mode;
`ifdef FIB_SEQ_ENGINE_MOD_EN
                        m_q    <= bus.modulus;
`endif
                        ovf_q  <= 1'b0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Start strobes are ignored here; the job runs to completion.
                    if (cnt != '0) begin
                        a     <= b;
                        b     <= next_b;
                        cnt   <= cnt - 1'b1;
                        ovf_q <= ovf_q | carry;
                    end else begin
                        result_q <= a;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
